// File: rtl/hwpe_stream_package.sv
// -----------------------------------------------------------------------------
// hwpe_stream_package
//
// Shared types and constants for the buffered HWPE stream merge.
//
//   HWPE_STREAM_MERGE_MAX_LANES : upper bound on lanes carried by the flags
//                                 struct. Bits above NB_IN_STREAMS read 0.
//   hwpe_stream_merge_flags_t   : per-lane empty / full status vectors.
//   hwpe_stream_merge_cnt_width : occupancy counter width for a lane FIFO,
//                                 log2(depth)+1. The extra bit lets the
//                                 counter hold the value "depth" when full.
// -----------------------------------------------------------------------------
package hwpe_stream_package;

    localparam int unsigned HWPE_STREAM_MERGE_MAX_LANES = 16;

    typedef struct packed {
        logic [HWPE_STREAM_MERGE_MAX_LANES-1:0] empty;
        logic [HWPE_STREAM_MERGE_MAX_LANES-1:0] full;
    } hwpe_stream_merge_flags_t;

    function automatic int unsigned hwpe_stream_merge_cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hwpe_stream_merge_buffered_if.sv
// -----------------------------------------------------------------------------
// hwpe_stream_intf_stream
//
// HWPE stream bundle used for every lane and for the merged output.
//
//   valid : producer has a word on data/strb.
//   ready : consumer accepts the word.
//   data  : DATA_WIDTH-bit payload.
//   strb  : DATA_WIDTH/8 byte strobes.
//
// Handshake: a word transfers on a rising clock edge where valid and ready are
// both 1. Once valid is raised, the producer keeps valid, data and strb stable
// until that transfer happens; ready may be raised or dropped freely and must
// never be a function of valid on the same side.
//
// Modports: master drives valid/data/strb, slave drives ready.
// -----------------------------------------------------------------------------
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport master (
        output valid,
        output data,
        output strb,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  strb,
        output ready
    );

endinterface

// File: rtl/hwpe_stream_merge_lane.sv
// -----------------------------------------------------------------------------
// hwpe_stream_merge_lane
//
// Single-lane elastic FIFO for the buffered stream merge.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous clear; pointers and count return to zero and
//                   any push/pop presented in the same cycle is dropped
//   push_i        : write data_i/strb_i at the tail (ignored while full)
//   data_i/strb_i : word to push
//   pop_i         : drop the head entry (ignored while empty)
//   data_o/strb_o : head entry; reads zero while the FIFO is empty
//   empty_o       : no entries
//   full_o        : FIFO_DEPTH entries
//   count_o       : current occupancy
//
// The head is read straight from storage, so a word pushed at an edge is
// visible only after that edge (no fall-through from data_i).
// -----------------------------------------------------------------------------
module hwpe_stream_merge_lane
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned CNT_W      = hwpe_stream_merge_cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [STRB_WIDTH-1:0] strb_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [STRB_WIDTH-1:0] strb_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [CNT_W-1:0]      count_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
    logic [STRB_WIDTH-1:0] strb_mem_q [FIFO_DEPTH];

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    logic do_push;
    logic do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign count_o = cnt_q;

    // A full FIFO refuses the push even if the head is popped in the same
    // cycle; this keeps the upstream ready free of any downstream dependency.
    assign do_push = push_i & ~full_o & ~clear_i;
    assign do_pop  = pop_i & ~empty_o & ~clear_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (do_push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            data_mem_q[wptr_q] <= data_i;
            strb_mem_q[wptr_q] <= strb_i;
        end
    end

    assign data_o = empty_o ? '0 : data_mem_q[rptr_q];
    assign strb_o = empty_o ? '0 : strb_mem_q[rptr_q];

endmodule

// File: rtl/hwpe_stream_merge_buffered.sv
// -----------------------------------------------------------------------------
// hwpe_stream_merge_buffered
//
// Merges NB_IN_STREAMS HWPE streams into one wide stream. Every lane has its
// own FIFO so producers with different latencies need not be valid together.
// Lane ii occupies bits [(ii+1)*DATA_WIDTH_IN-1 : ii*DATA_WIDTH_IN] of the
// output data (and the matching strobe slice).
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous clear of all lane FIFOs (and output slice)
//   lane_en_i     : per-lane enable mask; disabled lanes are not popped,
//                   read not-ready and contribute zero data/strobe
//   stream_i      : NB_IN_STREAMS input lanes (slave side)
//   stream_o      : merged output (master side)
//   flags_o       : per-lane empty/full, upper unused bits read 0
//
// Build option:
//   HWPE_STREAM_MERGE_BUFFERED_OUT_REG_EN - inserts a one-entry register slice
//   after the pop logic, so stream_o comes straight from flops (2-cycle
//   latency). Without it the output is driven combinationally from the FIFO
//   heads (1-cycle latency).
//
// Input ready depends only on lane_en_i and the lane's registered fill level,
// so there is no ready-to-ready combinational path through the block.
// -----------------------------------------------------------------------------
module hwpe_stream_merge_buffered
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_IN_STREAMS = 2,
    parameter int unsigned DATA_WIDTH_IN = 32,
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic [NB_IN_STREAMS-1:0] lane_en_i,
    hwpe_stream_intf_stream.slave    stream_i [NB_IN_STREAMS-1:0],
    hwpe_stream_intf_stream.master   stream_o,
    output hwpe_stream_merge_flags_t flags_o
);

    localparam int unsigned STRB_IN = DATA_WIDTH_IN / 8;
    localparam int unsigned CNT_W   = hwpe_stream_merge_cnt_width(FIFO_DEPTH);
    localparam int unsigned DW_OUT  = NB_IN_STREAMS * DATA_WIDTH_IN;
    localparam int unsigned SW_OUT  = NB_IN_STREAMS * STRB_IN;

    logic [NB_IN_STREAMS-1:0] lane_empty;
    logic [NB_IN_STREAMS-1:0] lane_full;
    logic [NB_IN_STREAMS-1:0] lane_ok;
    logic [DW_OUT-1:0]        head_data;
    logic [SW_OUT-1:0]        head_strb;
    logic                     fifo_valid;
    logic                     pop;

    for (genvar ii = 0; ii < NB_IN_STREAMS; ii++) begin : gen_lane
        logic                     lane_ready;
        logic                     lane_push;
        logic [DATA_WIDTH_IN-1:0] lane_data;
        logic [STRB_IN-1:0]       lane_strb;
        logic [CNT_W-1:0]         lane_count;

        assign lane_ready         = lane_en_i[ii] & ~lane_full[ii];
        assign stream_i[ii].ready = lane_ready;
        assign lane_push          = stream_i[ii].valid & lane_ready;

        hwpe_stream_merge_lane #(
            .DATA_WIDTH (DATA_WIDTH_IN),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) i_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear_i),
            .push_i  (lane_push),
            .data_i  (stream_i[ii].data),
            .strb_i  (stream_i[ii].strb),
            .pop_i   (pop & lane_en_i[ii]),
            .data_o  (lane_data),
            .strb_o  (lane_strb),
            .empty_o (lane_empty[ii]),
            .full_o  (lane_full[ii]),
            .count_o (lane_count)
        );

        // A disabled lane never blocks the merge; an enabled one needs a word.
        assign lane_ok[ii] = ~lane_en_i[ii] | (lane_count != '0);

        assign head_data[ii*DATA_WIDTH_IN +: DATA_WIDTH_IN] = lane_en_i[ii] ? lane_data : '0;
        assign head_strb[ii*STRB_IN +: STRB_IN]             = lane_en_i[ii] ? lane_strb : '0;
    end

    // An all-zero mask must not look like "every enabled lane has data".
    assign fifo_valid = (|lane_en_i) & (&lane_ok);

`ifdef HWPE_STREAM_MERGE_BUFFERED_OUT_REG_EN
    logic              out_valid_q, out_valid_d;
    logic [DW_OUT-1:0] out_data_q,  out_data_d;
    logic [SW_OUT-1:0] out_strb_q,  out_strb_d;
    logic              load;

    // The slice reloads in the same cycle it drains, keeping one word/cycle.
    assign load = fifo_valid & (~out_valid_q | stream_o.ready);
    assign pop  = load;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        if (clear_i) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_strb_d  = '0;
        end else if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = head_data;
            out_strb_d  = head_strb;
        end else if (stream_o.ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
        end
    end

    assign stream_o.valid = out_valid_q;
    assign stream_o.data  = out_data_q;
    assign stream_o.strb  = out_strb_q;
`else
    // Every enabled lane pops together, so lane words stay aligned.
    assign pop            = fifo_valid & stream_o.ready;
    assign stream_o.valid = fifo_valid;
    assign stream_o.data  = head_data;
    assign stream_o.strb  = head_strb;
`endif

    always_comb begin
        flags_o                           = '0;
        flags_o.empty[NB_IN_STREAMS-1:0] = lane_empty;
        flags_o.full[NB_IN_STREAMS-1:0]  = lane_full;
    end

endmodule

// File: tb/tb_hwpe_stream_merge_buffered.sv
// -----------------------------------------------------------------------------
// tb_hwpe_stream_merge_buffered
//
// Directed and random stimulus for the buffered stream merge (2 lanes x 32 bit,
// depth 2). The reference model keeps one queue of words per lane and derives
// valid/ready/flags/data from queue sizes and heads every cycle.
// -----------------------------------------------------------------------------
module tb_hwpe_stream_merge_buffered;
    import hwpe_stream_package::*;

    localparam int NB    = 2;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int LW    = DW + SW;
    localparam int DEPTH = 2;
`ifdef HWPE_STREAM_MERGE_BUFFERED_OUT_REG_EN
    localparam bit OUT_REG = 1'b1;
`else
    localparam bit OUT_REG = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    logic [NB-1:0] lane_en;
    logic          in_valid [NB];
    logic [DW-1:0] in_data  [NB];
    logic [SW-1:0] in_strb  [NB];
    logic [NB-1:0] in_ready;
    logic          out_ready;
    hwpe_stream_merge_flags_t flags;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW))      in_if [NB-1:0] ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(NB * DW)) out_if ();

    for (genvar g = 0; g < NB; g++) begin : gen_in
        assign in_if[g].valid = in_valid[g];
        assign in_if[g].data  = in_data[g];
        assign in_if[g].strb  = in_strb[g];
        assign in_ready[g]    = in_if[g].ready;
    end
    assign out_if.ready = out_ready;

    hwpe_stream_merge_buffered #(
        .NB_IN_STREAMS (NB),
        .DATA_WIDTH_IN (DW),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clear_i   (clear),
        .lane_en_i (lane_en),
        .stream_i  (in_if),
        .stream_o  (out_if),
        .flags_o   (flags)
    );

    // ---------------- model / scoreboard state ----------------
    logic [LW-1:0]      lane_q [NB][$];   // words held inside the block, {strb,data}
    logic [LW-1:0]      drv_q  [NB][$];   // words still to be offered per lane
    bit                 slice_v;
    logic [NB*DW-1:0]   slice_d;
    logic [NB*SW-1:0]   slice_s;
    bit                 acc  [NB];
    bit                 hold [NB];
    int                 checks = 0;
    int                 errors = 0;
    int                 fires  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit heads_ready();
        if (lane_en == '0) return 1'b0;
        for (int i = 0; i < NB; i++)
            if (lane_en[i] && lane_q[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NB*DW-1:0] model_data();
        logic [NB*DW-1:0] d;
        logic [LW-1:0]    w;
        d = '0;
        for (int i = 0; i < NB; i++)
            if (lane_en[i] && lane_q[i].size() != 0) begin
                w = lane_q[i][0];
                d[i*DW +: DW] = w[DW-1:0];
            end
        return d;
    endfunction

    function automatic logic [NB*SW-1:0] model_strb();
        logic [NB*SW-1:0] s;
        logic [LW-1:0]    w;
        s = '0;
        for (int i = 0; i < NB; i++)
            if (lane_en[i] && lane_q[i].size() != 0) begin
                w = lane_q[i][0];
                s[i*SW +: SW] = w[LW-1:DW];
            end
        return s;
    endfunction

    function automatic void pop_enabled();
        for (int i = 0; i < NB; i++)
            if (lane_en[i]) void'(lane_q[i].pop_front());
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < NB; i++) lane_q[i].delete();
        slice_v = 1'b0;
    endfunction

    // One clock: check outputs at the falling edge, advance the model, and
    // return 1 time unit after the next rising edge.
    task automatic cycle();
        bit               ev;
        bit               ld;
        logic [NB-1:0]    er;
        logic [15:0]      ee;
        logic [15:0]      ef;
        logic [NB*DW-1:0] ed;
        logic [NB*SW-1:0] es;
        @(negedge clk);
        ee = '0;
        ef = '0;
        for (int i = 0; i < NB; i++) begin
            er[i] = lane_en[i] && (lane_q[i].size() < DEPTH);
            ee[i] = (lane_q[i].size() == 0);
            ef[i] = (lane_q[i].size() == DEPTH);
        end
        if (OUT_REG) begin
            ev = slice_v;
            ed = slice_d;
            es = slice_s;
        end else begin
            ev = heads_ready();
            ed = model_data();
            es = model_strb();
        end
        chk("out_valid", 64'(out_if.valid), 64'(ev));
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("flags_empty", 64'(flags.empty), 64'(ee));
        chk("flags_full", 64'(flags.full), 64'(ef));
        if (ev) begin
            chk("out_data", out_if.data, ed);
            chk("out_strb", 64'(out_if.strb), 64'(es));
        end
        if (out_if.valid && out_ready) fires++;
        for (int i = 0; i < NB; i++) acc[i] = 1'b0;
        if (clear) begin
            model_flush();
        end else begin
            if (OUT_REG) begin
                ld = heads_ready() && (!slice_v || out_ready);
                if (ld) begin
                    slice_d = model_data();
                    slice_s = model_strb();
                    pop_enabled();
                    slice_v = 1'b1;
                end else if (out_ready) begin
                    slice_v = 1'b0;
                end
            end else if (ev && out_ready) begin
                pop_enabled();
            end
            for (int i = 0; i < NB; i++)
                if (in_valid[i] && er[i]) begin
                    acc[i] = 1'b1;
                    lane_q[i].push_back({in_strb[i], in_data[i]});
                end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic step(input int vp, input int rp);
        logic [LW-1:0] w;
        for (int i = 0; i < NB; i++) begin
            in_valid[i] = (drv_q[i].size() != 0) && (hold[i] || ($urandom_range(99) < vp));
            if (in_valid[i]) begin
                w = drv_q[i][0];
                in_data[i] = w[DW-1:0];
                in_strb[i] = w[LW-1:DW];
            end
        end
        out_ready = ($urandom_range(99) < rp);
        cycle();
        for (int i = 0; i < NB; i++) begin
            if (acc[i]) void'(drv_q[i].pop_front());
            hold[i] = in_valid[i] && !acc[i];
        end
    endtask

    function automatic bit all_idle();
        if (slice_v) return 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (drv_q[i].size() != 0) return 1'b0;
            if (lane_en[i] && lane_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input string tag, input int vp, input int rp, input int budget);
        bit done;
        done = all_idle();
        for (int n = 0; n < budget && !done; n++) begin
            step(vp, rp);
            done = all_idle();
        end
        chk(tag, 64'(done), 64'(1));
    endtask

    function automatic logic [LW-1:0] rnd_word();
        return {4'($urandom_range(15)), 32'($urandom)};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        lane_en   = 2'b11;
        out_ready = 1'b0;
        for (int i = 0; i < NB; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = '0;
            in_strb[i]  = '0;
            hold[i]     = 1'b0;
            acc[i]      = 1'b0;
        end
        slice_v = 1'b0;
        slice_d = '0;
        slice_s = '0;

        // Reset values
        #2;
        chk("rst_valid", 64'(out_if.valid), 64'(0));
        chk("rst_data", out_if.data, 64'(0));
        chk("rst_strb", 64'(out_if.strb), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(2'b11));
        chk("rst_empty", 64'(flags.empty), 64'(16'h0003));
        chk("rst_full", 64'(flags.full), 64'(0));
        lane_en = 2'b01;
        #1;
        chk("rst_ready_mask", 64'(in_ready), 64'(2'b01));
        lane_en = 2'b11;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Scenario 1: lanes arrive three cycles apart
        drv_q[0].push_back({4'hF, 32'h0000_000A});
        step(100, 0);
        step(100, 0);
        step(100, 0);
        drv_q[1].push_back({4'hF, 32'h0000_000B});
        step(100, 0);
        chk("s1_valid_first", 64'(out_if.valid), 64'(!OUT_REG));
        step(100, 0);
        chk("s1_valid_late", 64'(out_if.valid), 64'(1));
        chk("s1_data", out_if.data, 64'h0000_000B_0000_000A);
        drain("s1_drain", 100, 100, 20);

        // Scenario 2: lane0 fills with output stalled, then drains in order
        for (int k = 0; k < 3; k++) drv_q[0].push_back(rnd_word());
        step(100, 0);
        step(100, 0);
        chk("s2_ready0_full", 64'(in_ready[0]), 64'(0));
        chk("s2_full0", 64'(flags.full[0]), 64'(1));
        step(100, 0);
        for (int k = 0; k < 3; k++) drv_q[1].push_back(rnd_word());
        drain("s2_drain", 100, 100, 30);
        chk("s2_ready0_back", 64'(in_ready[0]), 64'(1));

        // Scenario 3: lane1 keeps a word while masked, emitted after re-enable
        drv_q[1].push_back({4'h3, 32'hCAFE_0001});
        step(100, 100);
        step(100, 100);
        lane_en = 2'b01;
        for (int k = 0; k < 3; k++) drv_q[0].push_back(rnd_word());
        drain("s3_masked_drain", 100, 100, 30);
        chk("s3_ready1_masked", 64'(in_ready[1]), 64'(0));
        chk("s3_lane1_kept", 64'(flags.empty[1]), 64'(0));
        lane_en = 2'b11;
        drv_q[0].push_back({4'h5, 32'hBEEF_0002});
        drain("s3_reenable_drain", 100, 100, 20);

        // Scenario 4: clear drops buffered words
        drv_q[0].push_back(rnd_word());
        drv_q[0].push_back(rnd_word());
        drv_q[1].push_back(rnd_word());
        for (int k = 0; k < 3; k++) step(100, 0);
        clear = 1'b1;
        step(100, 0);
        clear = 1'b0;
        chk("s4_empty_after_clear", 64'(flags.empty), 64'(16'h0003));
        chk("s4_valid_after_clear", 64'(out_if.valid), 64'(0));
        for (int k = 0; k < 3; k++) step(100, 100);
        drv_q[0].push_back(rnd_word());
        drv_q[1].push_back(rnd_word());
        drain("s4_fresh_drain", 100, 100, 20);

        // Scenario 5: random streaming with random output backpressure
        fires = 0;
        for (int k = 0; k < 100; k++) begin
            drv_q[0].push_back(rnd_word());
            drv_q[1].push_back(rnd_word());
        end
        drain("s5_random_drain", 70, 60, 3000);
        chk("s5_word_count", 64'(fires), 64'(100));

        // Throughput: both lanes streaming, output always ready
        for (int k = 0; k < 40; k++) begin
            drv_q[0].push_back(rnd_word());
            drv_q[1].push_back(rnd_word());
        end
        for (int k = 0; k < 6; k++) step(100, 100);
        fires = 0;
        for (int k = 0; k < 20; k++) step(100, 100);
        chk("s5_throughput", 64'(fires), 64'(20));
        drain("s5_tp_drain", 100, 100, 60);

        // Reset mid-operation loses all contents
        drv_q[0].push_back(rnd_word());
        drv_q[1].push_back(rnd_word());
        drv_q[0].push_back(rnd_word());
        step(100, 0);
        step(100, 0);
        for (int i = 0; i < NB; i++) begin
            in_valid[i] = 1'b0;
            hold[i]     = 1'b0;
            drv_q[i].delete();
        end
        rst_n = 1'b0;
        #1;
        chk("s6_rst_empty", 64'(flags.empty), 64'(16'h0003));
        chk("s6_rst_valid", 64'(out_if.valid), 64'(0));
        model_flush();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(100, 100);
        drv_q[0].push_back(rnd_word());
        drv_q[1].push_back(rnd_word());
        drain("s6_post_rst_drain", 100, 100, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
